// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder/subtractor.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nnib);
        return (nnib <= 1) ? 1 : $clog2(nnib);
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_cla_4.sv
// Existing 4-bit carry-look-ahead adder slice, used as the nibble datapath.
module CLA_4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign S    = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/sub computed one nibble per cycle through a single CLA_4 slice.
// Optional zero flag output zf is enabled with NSA_ZERO_FLAG_EN.
module nibble_serial_addsub
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef NSA_ZERO_FLAG_EN
    ,
    output logic             zf
`endif
);

    localparam int NNIB  = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NNIB);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     sum_nxt;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic                 a_msb;
    logic                 b_msb;
    logic                 last_nib;
    logic [NIBBLE_W-1:0]  nib_sum;
    logic                 nib_cout;

    CLA_4 u_cla (
        .A    (a_reg[NIBBLE_W-1:0]),
        .B    (b_reg[NIBBLE_W-1:0]),
        .Cin  (carry),
        .S    (nib_sum),
        .Cout (nib_cout)
    );

    assign in_ready = (state == IDLE);
    assign last_nib = (idx == IDX_W'(NNIB - 1));

    // Each nibble result enters at the top, so after NNIB shifts the LSB nibble sits at the bottom.
    assign sum_nxt = (sum >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_nib)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
`ifdef NSA_ZERO_FLAG_EN
            zf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        carry <= sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum   <= sum_nxt;
                    a_reg <= a_reg >> NIBBLE_W;
                    b_reg <= b_reg >> NIBBLE_W;
                    carry <= nib_cout;
                    idx   <= idx + 1'b1;
                    if (last_nib) begin
                        cout      <= nib_cout;
                        ovf       <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
                        out_valid <= 1'b1;
`ifdef NSA_ZERO_FLAG_EN
                        zf        <= (sum_nxt == '0);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
